// File: rtl/sync_fifo_gen2_pkg.sv
// sync_fifo_gen2_pkg: default sizes, clog2 and parameter legality check for sync_fifo_gen2
package sync_fifo_gen2_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic bit params_ok(input int dw, input int depth, input int aw, input int af, input int ae);
    return dw >= 1 && depth >= 2 && (1 << aw) == depth && af >= 1 && af <= depth && ae >= 0 && ae < af;
  endfunction
endpackage

// File: rtl/sync_fifo_gen2_if.sv
// sync_fifo_gen2_if: producer/consumer handshake, data and status bundle of sync_fifo_gen2
interface sync_fifo_gen2_if import sync_fifo_gen2_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = clog2(DEF_DEPTH)
);
  logic w_en;
  logic r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [ADDR_WIDTH:0] count;
  logic overflow;
  logic underflow;
  modport master (
    output w_en, r_en, data_in,
    input data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input w_en, r_en, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: DEPTH x DATA_WIDTH storage, synchronous write port, asynchronous read port, no reset
module fifo_mem_dp import sync_fifo_gen2_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_gen2.sv
// sync_fifo_gen2: parametrised single-clock FIFO with count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_gen2 import sync_fifo_gen2_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic rst,
  sync_fifo_gen2_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(AE_THRESH);
  if (!params_ok(DATA_WIDTH, DEPTH, ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_gen2: illegal DEPTH/ADDR_WIDTH/threshold combination");
  end
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic r_acc, w_acc, ovf_q, udf_q;
  // a read frees a slot in the same edge, so a full FIFO can still take a write alongside it
  assign r_acc = bus.r_en && !bus.empty;
  assign w_acc = bus.w_en && (!bus.full || r_acc);
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .we(w_acc),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (w_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (r_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      cnt <= cnt + (ADDR_WIDTH+1)'(w_acc) - (ADDR_WIDTH+1)'(r_acc);
      ovf_q <= bus.w_en && !w_acc;
      udf_q <= bus.r_en && !r_acc;
    end
  end
  assign bus.count = cnt;
  assign bus.empty = cnt == '0;
  assign bus.full = cnt == FULL_CNT;
  assign bus.almost_full = cnt >= AF_CNT;
  assign bus.almost_empty = cnt <= AE_CNT;
  assign bus.overflow = ovf_q;
  assign bus.underflow = udf_q;
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = rdata;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= '0;
    else if (r_acc) dout_q <= rdata;
  end
  assign bus.data_out = dout_q;
`endif
endmodule

// File: tb/tb_sync_fifo_gen2.sv
// tb_sync_fifo_gen2: directed and random stimulus against a queue-based model of sync_fifo_gen2
module tb_sync_fifo_gen2;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int AF = 6;
  localparam int AE = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  sync_fifo_gen2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  sync_fifo_gen2 #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_dout = '0;
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask
  task automatic check_all(input string ph);
    int n = q.size();
    chk({ph, ":count"}, 32'(bus.count), 32'(n));
    chk({ph, ":empty"}, 32'(bus.empty), 32'(n == 0));
    chk({ph, ":full"}, 32'(bus.full), 32'(n == DEPTH));
    chk({ph, ":almost_full"}, 32'(bus.almost_full), 32'(n >= AF));
    chk({ph, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
    chk({ph, ":overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({ph, ":underflow"}, 32'(bus.underflow), 32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) chk({ph, ":data_out"}, 32'(bus.data_out), 32'(q[0]));
`else
    chk({ph, ":data_out"}, 32'(bus.data_out), 32'(exp_dout));
`endif
  endtask
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input string ph);
    bit ra, wa;
    bus.w_en = w;
    bus.r_en = r;
    bus.data_in = d;
    ra = r && q.size() > 0;
    wa = w && (q.size() < DEPTH || ra);
    @(posedge clk);
    #1;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    exp_ovf = w && !wa;
    exp_udf = r && !ra;
    check_all(ph);
  endtask
  initial begin
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 model_reset();
    check_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, DW'(i * 17), "t1_fill");
    cyc(1'b1, 1'b0, 8'h99, "t2_overflow");
    cyc(1'b0, 1'b0, 8'h00, "t2_idle");
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, "t3_drain");
    cyc(1'b0, 1'b1, 8'h00, "t3_underflow");
    cyc(1'b0, 1'b0, 8'h00, "t3_idle");
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, DW'(i * 17), "t4_fill");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'hA0 + DW'(i), "t4_rw_full");
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, "t4_drain");
    cyc(1'b1, 1'b1, 8'h3C, "t5_rw_empty");
    cyc(1'b0, 1'b1, 8'h00, "t5_read");
    cyc(1'b0, 1'b0, 8'h00, "t5_idle");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'($urandom), "t6_fill");
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("t6_async_rst");
    @(negedge clk) rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h42, "t6_write");
    cyc(1'b0, 1'b1, 8'h00, "t6_read");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'($urandom), "t6_wrap_fill");
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 8'h00, "t6_wrap_drain");
    end
    for (int i = 0; i < 600; i++) begin
      int pw = (i / 100) % 2 == 0 ? 75 : 25;
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw, DW'($urandom), "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
